// File: rtl/routed_fifos_pkg.sv
// Shared definitions for the routed/arbitrated multi-FIFO datapath:
// default sizes plus width-derivation and flat-packing helpers.
package routed_fifos_pkg;

    localparam int DEF_NUM_REQS = 2;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEPTH    = 4;

    // Width of a destination index selecting one of n FIFOs.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a read/write pointer addressing 0..depth-1.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // LSB of lane idx inside a flat bus of w-bit lanes.
    function automatic int slice_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with sticky overflow/underflow
// flags. Depth need not be a power of two; pointers wrap by explicit compare.
module sync_fifo
    import routed_fifos_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CWID  = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic [CWID-1:0]  count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PWID = ptr_width(DEPTH);
    localparam logic [PWID-1:0] LAST_PTR = PWID'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PWID-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PWID-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CWID-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             push_ok, pop_ok;

    function automatic logic [PWID-1:0] next_ptr(input logic [PWID-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PWID'(1);
    endfunction

    // Status comes only from the registered count, so a same-cycle pop never
    // makes room for a push into a full FIFO.
    assign empty   = (count_q == '0);
    assign full    = (count_q == CWID'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next-state computation for pointers, occupancy and sticky flags.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  | (push && full);
        underflow_d = underflow_q | (pop && empty);
        if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CWID'(1);
            2'b01:   count_d = count_q - CWID'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; stale words are unreachable once count is cleared.
        if (push_ok) mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out  = empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef FORMAL
    always @(posedge clk) begin
        if (!rst) begin
            assert (int'(count_q) <= DEPTH);
            assert (empty == (count_q == '0));
            assert (full == (count_q == CWID'(DEPTH)));
            assert (((int'(wr_ptr_q) - int'(rd_ptr_q) + DEPTH) % DEPTH) == (int'(count_q) % DEPTH));
        end
    end
`endif

endmodule

// File: rtl/routed_fifos.sv
// Distribution side of the multi-FIFO datapath: one producer stream is
// steered by dest into one of NUM_REQS FIFOs, each drained by its own pop.
module routed_fifos
    import routed_fifos_pkg::*;
#(
    parameter  int NUM_REQS = DEF_NUM_REQS,
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    localparam int DWID     = idx_width(NUM_REQS),
    localparam int CWID     = cnt_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DWID-1:0]          dest,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     in_ready,
    input  logic [NUM_REQS-1:0]      pop,
    output logic [NUM_REQS*WIDTH-1:0] flat_data_out,
    output logic [NUM_REQS-1:0]      empty,
    output logic [NUM_REQS-1:0]      full,
    output logic [NUM_REQS*CWID-1:0] flat_count,
    output logic [NUM_REQS-1:0]      overflow,
    output logic [NUM_REQS-1:0]      underflow,
    output logic                     bad_dest
);

    logic                dest_ok;
    logic                full_sel;
    logic [NUM_REQS-1:0] push_vec;
    logic                bad_dest_q, bad_dest_d;

    assign dest_ok = (int'(dest) < NUM_REQS);

    // Decode dest into a one-hot push and pick that FIFO's full flag.
    always_comb begin
        full_sel = 1'b0;
        push_vec = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (int'(dest) == i) begin
                full_sel    = full[i];
                push_vec[i] = push;
            end
        end
    end

    assign in_ready   = dest_ok && !full_sel;
    assign bad_dest_d = bad_dest_q | (push && !dest_ok);

    // Sticky out-of-range destination flag.
    always_ff @(posedge clk) begin
        if (rst) bad_dest_q <= 1'b0;
        else     bad_dest_q <= bad_dest_d;
    end

    assign bad_dest = bad_dest_q;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_fifo
        sync_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_vec[g]),
            .pop       (pop[g]),
            .data_in   (data_in),
            .data_out  (flat_data_out[slice_lsb(g, WIDTH) +: WIDTH]),
            .empty     (empty[g]),
            .full      (full[g]),
            .count     (flat_count[slice_lsb(g, CWID) +: CWID]),
            .overflow  (overflow[g]),
            .underflow (underflow[g])
        );
    end

endmodule

// File: tb/tb_routed_fifos.sv
// Directed bench for routed_fifos: a 2x4 instance driven from a vector
// table, and a 3x3 instance for wrap streaming, bad dest and mid-run reset.
module tb_routed_fifos;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Instance A: NUM_REQS=2, DEPTH=4
    logic        rst2, push2, dest2, rdy2, bad2;
    logic [7:0]  din2;
    logic [1:0]  pop2, empty2, full2, ovf2, udf2;
    logic [15:0] fdo2;
    logic [5:0]  fcnt2;

    routed_fifos #(.NUM_REQS(2), .WIDTH(8), .DEPTH(4)) dut2 (
        .clk(clk), .rst(rst2), .push(push2), .dest(dest2), .data_in(din2),
        .in_ready(rdy2), .pop(pop2), .flat_data_out(fdo2), .empty(empty2),
        .full(full2), .flat_count(fcnt2), .overflow(ovf2), .underflow(udf2),
        .bad_dest(bad2)
    );

    // Instance B: NUM_REQS=3, DEPTH=3
    logic        rst3, push3, rdy3, bad3;
    logic [1:0]  dest3;
    logic [7:0]  din3;
    logic [2:0]  pop3, empty3, full3, ovf3, udf3;
    logic [23:0] fdo3;
    logic [5:0]  fcnt3;

    routed_fifos #(.NUM_REQS(3), .WIDTH(8), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst3), .push(push3), .dest(dest3), .data_in(din3),
        .in_ready(rdy3), .pop(pop3), .flat_data_out(fdo3), .empty(empty3),
        .full(full3), .flat_count(fcnt3), .overflow(ovf3), .underflow(udf3),
        .bad_dest(bad3)
    );

    typedef struct {
        logic       push;
        logic       dest;
        logic [7:0] din;
        logic [1:0] pop;
        logic       rdy;
        logic [2:0] cnt0;
        logic [2:0] cnt1;
        logic [7:0] head0;
        logic [7:0] head1;
        logic [1:0] empty;
        logic [1:0] full;
        logic [1:0] ovf;
        logic [1:0] udf;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] model [$];
        int sent, got;
        logic do_push, do_pop;

        //             push  dest  din    pop    rdy   c0    c1    h0     h1     empty  full   ovf    udf
        vecs[0]  = '{1'b1, 1'b0, 8'hA1, 2'b00, 1'b1, 3'd1, 3'd0, 8'hA1, 8'h00, 2'b10, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{1'b1, 1'b0, 8'hA2, 2'b00, 1'b1, 3'd2, 3'd0, 8'hA1, 8'h00, 2'b10, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{1'b1, 1'b1, 8'hB1, 2'b00, 1'b1, 3'd2, 3'd1, 8'hA1, 8'hB1, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[3]  = '{1'b1, 1'b0, 8'hA3, 2'b00, 1'b1, 3'd3, 3'd1, 8'hA1, 8'hB1, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[4]  = '{1'b1, 1'b0, 8'hA4, 2'b00, 1'b1, 3'd4, 3'd1, 8'hA1, 8'hB1, 2'b00, 2'b01, 2'b00, 2'b00};
        vecs[5]  = '{1'b1, 1'b0, 8'hA5, 2'b00, 1'b0, 3'd4, 3'd1, 8'hA1, 8'hB1, 2'b00, 2'b01, 2'b01, 2'b00};
        vecs[6]  = '{1'b1, 1'b0, 8'hA6, 2'b01, 1'b0, 3'd3, 3'd1, 8'hA2, 8'hB1, 2'b00, 2'b00, 2'b01, 2'b00};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 3'd2, 3'd1, 8'hA3, 8'hB1, 2'b00, 2'b00, 2'b01, 2'b00};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 3'd1, 3'd1, 8'hA4, 8'hB1, 2'b00, 2'b00, 2'b01, 2'b00};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 3'd0, 3'd1, 8'h00, 8'hB1, 2'b01, 2'b00, 2'b01, 2'b00};
        vecs[10] = '{1'b1, 1'b0, 8'h55, 2'b01, 1'b1, 3'd1, 3'd1, 8'h55, 8'hB1, 2'b00, 2'b00, 2'b01, 2'b01};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 2'b11, 2'b00, 2'b01, 2'b01};
        vecs[12] = '{1'b0, 1'b1, 8'h00, 2'b10, 1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 2'b11, 2'b00, 2'b01, 2'b11};
        vecs[13] = '{1'b1, 1'b1, 8'hC1, 2'b00, 1'b1, 3'd0, 3'd1, 8'h00, 8'hC1, 2'b01, 2'b00, 2'b01, 2'b11};
        vecs[14] = '{1'b1, 1'b1, 8'hC2, 2'b10, 1'b1, 3'd0, 3'd1, 8'h00, 8'hC2, 2'b01, 2'b00, 2'b01, 2'b11};

        // Reset both instances with idle inputs.
        rst2 = 1'b1; push2 = 1'b0; dest2 = 1'b0; din2 = '0; pop2 = '0;
        rst3 = 1'b1; push3 = 1'b0; dest3 = '0;   din3 = '0; pop3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst2 = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;
        check("reset empty", 32'(empty2), 32'h3);
        check("reset full", 32'(full2), 32'h0);
        check("reset count", 32'(fcnt2), 32'h0);
        check("reset data", 32'(fdo2), 32'h0);
        check("reset ovf", 32'(ovf2), 32'h0);
        check("reset udf", 32'(udf2), 32'h0);
        check("reset bad_dest", 32'(bad2), 32'h0);
        check("reset in_ready", 32'(rdy2), 32'h1);
        check("reset3 empty", 32'(empty3), 32'h7);

        // Table-driven sequence on the 2x4 instance.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            push2 = vecs[i].push; dest2 = vecs[i].dest;
            din2  = vecs[i].din;  pop2  = vecs[i].pop;
            #1;
            check($sformatf("v%0d in_ready", i), 32'(rdy2), 32'(vecs[i].rdy));
            @(posedge clk); #1;
            check($sformatf("v%0d count0", i), 32'(fcnt2[2:0]), 32'(vecs[i].cnt0));
            check($sformatf("v%0d count1", i), 32'(fcnt2[5:3]), 32'(vecs[i].cnt1));
            check($sformatf("v%0d head0", i), 32'(fdo2[7:0]), 32'(vecs[i].head0));
            check($sformatf("v%0d head1", i), 32'(fdo2[15:8]), 32'(vecs[i].head1));
            check($sformatf("v%0d empty", i), 32'(empty2), 32'(vecs[i].empty));
            check($sformatf("v%0d full", i), 32'(full2), 32'(vecs[i].full));
            check($sformatf("v%0d overflow", i), 32'(ovf2), 32'(vecs[i].ovf));
            check($sformatf("v%0d underflow", i), 32'(udf2), 32'(vecs[i].udf));
        end
        @(negedge clk);
        push2 = 1'b0; pop2 = '0;
        check("A bad_dest stays 0", 32'(bad2), 32'h0);

        // Stream 10 words through FIFO 1 of the depth-3 instance, popping
        // on alternate cycles so both pointers wrap several times.
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 60 && (sent < 10 || model.size() > 0); cyc++) begin
            @(negedge clk);
            do_push = (sent < 10) && (model.size() < 3);
            do_pop  = ((cyc % 2 == 1) || sent == 10) && (model.size() > 0);
            push3 = do_push;
            dest3 = 2'd1;
            din3  = 8'h10 + 8'(sent);
            pop3  = {1'b0, do_pop, 1'b0};
            @(posedge clk); #1;
            if (do_pop) begin
                void'(model.pop_front());
                got++;
            end
            if (do_push) begin
                model.push_back(8'h10 + 8'(sent));
                sent++;
            end
            check($sformatf("stream c%0d count1", cyc), 32'(fcnt3[3:2]), 32'(model.size()));
            check($sformatf("stream c%0d head1", cyc), 32'(fdo3[15:8]),
                  (model.size() > 0) ? 32'(model[0]) : 32'h0);
        end
        @(negedge clk);
        push3 = 1'b0; pop3 = '0;
        check("stream words popped", 32'(got), 32'd10);
        check("stream empty after drain", 32'(empty3), 32'h7);
        check("stream no flags", 32'({ovf3, udf3}), 32'h0);

        // Out-of-range destination: rejected, flagged, nothing stored.
        push3 = 1'b1; dest3 = 2'd3; din3 = 8'hEE;
        #1;
        check("bad dest in_ready", 32'(rdy3), 32'h0);
        @(posedge clk); #1;
        check("bad dest flag", 32'(bad3), 32'h1);
        check("bad dest counts", 32'(fcnt3), 32'h0);
        check("bad dest empty", 32'(empty3), 32'h7);

        // Push to the last FIFO only; other lanes untouched.
        @(negedge clk);
        dest3 = 2'd2; din3 = 8'h77;
        #1;
        check("dest2 in_ready", 32'(rdy3), 32'h1);
        @(posedge clk); #1;
        check("dest2 counts", 32'(fcnt3), 32'h10);
        check("dest2 head", 32'(fdo3), 32'h770000);

        // Two words into FIFO 0, then reset with a push/pop in the same cycle.
        @(negedge clk);
        dest3 = 2'd0; din3 = 8'h31;
        @(negedge clk);
        din3 = 8'h32;
        @(posedge clk); #1;
        check("pre-reset counts", 32'(fcnt3), 32'h12);
        @(negedge clk);
        rst3 = 1'b1; din3 = 8'h33; pop3 = 3'b100;
        @(posedge clk); #1;
        check("mid reset counts", 32'(fcnt3), 32'h0);
        check("mid reset empty", 32'(empty3), 32'h7);
        check("mid reset data", 32'(fdo3), 32'h0);
        check("mid reset flags", 32'({bad3, ovf3, udf3}), 32'h0);
        @(negedge clk);
        rst3 = 1'b0; pop3 = '0; din3 = 8'h44;
        @(posedge clk); #1;
        check("post reset head0", 32'(fdo3), 32'h44);
        check("post reset counts", 32'(fcnt3), 32'h1);
        @(negedge clk);
        push3 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
